// File: rtl/alu_issue_wb.sv
// Operand-issue / write-back stage wrapped around a 16-bit combinational ALU.
// It holds an 8-entry register file, forwards one result level, suppresses divide-by-zero and supports a global hold.
module alu_issue_wb #(
   parameter int DATA_W = 16,
   parameter int NREG   = 8,
   parameter int AW     = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              instr_valid,
   output logic              instr_ready,
   input  logic [3:0]        op,
   input  logic [AW-1:0]     rd,
   input  logic [AW-1:0]     rs1,
   input  logic [AW-1:0]     rs2,
   input  logic [DATA_W-1:0] imm,
   input  logic              hold,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   output logic [3:0]        alu_sel,
   input  logic [DATA_W-1:0] alu_result,
   output logic              wb_valid,
   output logic [AW-1:0]     wb_addr,
   output logic [DATA_W-1:0] wb_data,
   output logic              err_div0,
   input  logic [AW-1:0]     dbg_addr,
   output logic [DATA_W-1:0] dbg_data
);

   localparam logic [3:0] OP_LI   = 4'b0000;
   localparam logic [3:0] OP_PASS = 4'b0001;
   localparam logic [3:0] OP_DIV  = 4'b0111;

   logic [DATA_W-1:0] regs_q [NREG];
   logic [DATA_W-1:0] regs_d [NREG];

   logic [DATA_W-1:0] alu_a_q, alu_a_d;
   logic [DATA_W-1:0] alu_b_q, alu_b_d;
   logic [3:0]        alu_sel_q, alu_sel_d;
   logic              ex_valid_q, ex_valid_d;
   logic              ex_div0_q, ex_div0_d;
   logic [AW-1:0]     ex_rd_q, ex_rd_d;
   logic              wb_valid_q, wb_valid_d;
   logic [AW-1:0]     wb_addr_q, wb_addr_d;
   logic [DATA_W-1:0] wb_data_q, wb_data_d;
   logic              err_div0_q, err_div0_d;

   logic              accept;
   logic              wb_fire;
   logic [NREG-1:0]   wr_sel;
   logic [DATA_W-1:0] fwd_a;
   logic [DATA_W-1:0] fwd_b;

   assign instr_ready = ~hold;
   assign accept      = instr_valid & ~hold;
   assign wb_fire     = ex_valid_q & ~ex_div0_q & ~hold;

   // One-hot write decode; register 0 is never enabled so it stays zero.
   generate
      for (genvar gi = 0; gi < NREG; gi++) begin : g_wr_sel
         if (gi == 0) begin : g_zero
            assign wr_sel[gi] = 1'b0;
         end else begin : g_reg
            assign wr_sel[gi] = wb_fire & (ex_rd_q == AW'(gi));
         end
      end
   endgenerate

   // The in-flight result is the only value the register file does not yet hold.
   always_comb begin
      fwd_a = regs_q[rs1];
      if (rs1 == '0) begin
         fwd_a = '0;
      end else if (ex_valid_q && !ex_div0_q && (ex_rd_q == rs1)) begin
         fwd_a = alu_result;
      end
   end

   always_comb begin
      fwd_b = regs_q[rs2];
      if (rs2 == '0) begin
         fwd_b = '0;
      end else if (ex_valid_q && !ex_div0_q && (ex_rd_q == rs2)) begin
         fwd_b = alu_result;
      end
   end

   always_comb begin
      for (int i = 0; i < NREG; i++) begin
         regs_d[i] = wr_sel[i] ? alu_result : regs_q[i];
      end
   end

   always_comb begin
      alu_a_d    = alu_a_q;
      alu_b_d    = alu_b_q;
      alu_sel_d  = alu_sel_q;
      ex_valid_d = ex_valid_q;
      ex_div0_d  = ex_div0_q;
      ex_rd_d    = ex_rd_q;
      wb_valid_d = 1'b0;
      wb_addr_d  = wb_addr_q;
      wb_data_d  = wb_data_q;
      err_div0_d = 1'b0;

      if (!hold) begin
         if (accept) begin
            ex_valid_d = 1'b1;
            ex_rd_d    = rd;
            if (op == OP_LI) begin
               alu_a_d   = imm;
               alu_b_d   = '0;
               alu_sel_d = OP_PASS;
               ex_div0_d = 1'b0;
            end else begin
               alu_a_d   = fwd_a;
               alu_b_d   = fwd_b;
               alu_sel_d = op;
               ex_div0_d = (op == OP_DIV) && (fwd_b == '0);
            end
         end else begin
            ex_valid_d = 1'b0;
            ex_div0_d  = 1'b0;
         end

         if (ex_valid_q) begin
            wb_addr_d = ex_rd_q;
            if (ex_div0_q) begin
               err_div0_d = 1'b1;
            end else begin
               wb_valid_d = 1'b1;
               wb_data_d  = alu_result;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NREG; i++) begin
            regs_q[i] <= regs_d[i];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         alu_a_q    <= '0;
         alu_b_q    <= '0;
         alu_sel_q  <= OP_PASS;
         ex_valid_q <= 1'b0;
         ex_div0_q  <= 1'b0;
         ex_rd_q    <= '0;
         wb_valid_q <= 1'b0;
         wb_addr_q  <= '0;
         wb_data_q  <= '0;
         err_div0_q <= 1'b0;
      end else begin
         alu_a_q    <= alu_a_d;
         alu_b_q    <= alu_b_d;
         alu_sel_q  <= alu_sel_d;
         ex_valid_q <= ex_valid_d;
         ex_div0_q  <= ex_div0_d;
         ex_rd_q    <= ex_rd_d;
         wb_valid_q <= wb_valid_d;
         wb_addr_q  <= wb_addr_d;
         wb_data_q  <= wb_data_d;
         err_div0_q <= err_div0_d;
      end
   end

   assign alu_a    = alu_a_q;
   assign alu_b    = alu_b_q;
   assign alu_sel  = alu_sel_q;
   assign wb_valid = wb_valid_q;
   assign wb_addr  = wb_addr_q;
   assign wb_data  = wb_data_q;
   assign err_div0 = err_div0_q;
   assign dbg_data = regs_q[dbg_addr];

endmodule

// File: tb/tb_alu_issue_wb.sv
// Directed bench for alu_issue_wb: a small ALU model closes the loop,
// a vector table covers issue/forward/write-back, hand sequences cover reset and hold.
module tb_alu_issue_wb;

   localparam int DATA_W = 16;
   localparam int AW     = 3;

   logic              clk = 1'b0;
   logic              rst;
   logic              instr_valid;
   logic              instr_ready;
   logic [3:0]        op;
   logic [AW-1:0]     rd, rs1, rs2;
   logic [DATA_W-1:0] imm;
   logic              hold;
   logic [DATA_W-1:0] alu_a, alu_b;
   logic [3:0]        alu_sel;
   logic [DATA_W-1:0] alu_result;
   logic              wb_valid;
   logic [AW-1:0]     wb_addr;
   logic [DATA_W-1:0] wb_data;
   logic              err_div0;
   logic [AW-1:0]     dbg_addr;
   logic [DATA_W-1:0] dbg_data;

   int n_cmp  = 0;
   int n_fail = 0;

   alu_issue_wb #(.DATA_W(DATA_W), .NREG(8), .AW(AW)) dut (
      .clk        (clk),
      .rst        (rst),
      .instr_valid(instr_valid),
      .instr_ready(instr_ready),
      .op         (op),
      .rd         (rd),
      .rs1        (rs1),
      .rs2        (rs2),
      .imm        (imm),
      .hold       (hold),
      .alu_a      (alu_a),
      .alu_b      (alu_b),
      .alu_sel    (alu_sel),
      .alu_result (alu_result),
      .wb_valid   (wb_valid),
      .wb_addr    (wb_addr),
      .wb_data    (wb_data),
      .err_div0   (err_div0),
      .dbg_addr   (dbg_addr),
      .dbg_data   (dbg_data)
   );

   always #5 clk = ~clk;

   // ALU model: 1 = ADD, 2 = SUB, 7 = DIV.
   always_comb begin
      case (alu_sel)
         4'd1:    alu_result = alu_a + alu_b;
         4'd2:    alu_result = alu_a - alu_b;
         4'd7:    alu_result = (alu_b == '0) ? 16'hFFFF : alu_a / alu_b;
         default: alu_result = 16'h0000;
      endcase
   end

   typedef struct {
      logic              v;
      logic [3:0]        op;
      logic [AW-1:0]     rd, rs1, rs2;
      logic [DATA_W-1:0] imm;
      logic              e_wbv;
      logic              e_err;
      logic [AW-1:0]     e_addr;
      logic [DATA_W-1:0] e_data;
   } vec_t;

   vec_t vecs [10];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end else begin
         $display("ok   %s: %0h", name, act);
      end
   endtask

   task automatic drive(input logic v, input logic [3:0] o, input logic [AW-1:0] d,
                        input logic [AW-1:0] s1, input logic [AW-1:0] s2, input logic [DATA_W-1:0] im);
      instr_valid = v;
      op          = o;
      rd          = d;
      rs1         = s1;
      rs2         = s2;
      imm         = im;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_reg(input logic [AW-1:0] a, input logic [DATA_W-1:0] exp);
      dbg_addr = a;
      #1;
      chk($sformatf("reg r%0d", a), 32'(dbg_data), 32'(exp));
   endtask

   initial begin
      vecs[0] = '{1'b1, 4'd0, 3'd1, 3'd0, 3'd0, 16'h0007, 1'b0, 1'b0, 3'd0, 16'h0000};
      vecs[1] = '{1'b1, 4'd0, 3'd2, 3'd0, 3'd0, 16'h0003, 1'b1, 1'b0, 3'd1, 16'h0007};
      vecs[2] = '{1'b1, 4'd1, 3'd3, 3'd1, 3'd2, 16'h0000, 1'b1, 1'b0, 3'd2, 16'h0003};
      vecs[3] = '{1'b1, 4'd0, 3'd4, 3'd0, 3'd0, 16'h8000, 1'b1, 1'b0, 3'd3, 16'h000A};
      vecs[4] = '{1'b1, 4'd2, 3'd5, 3'd4, 3'd1, 16'h0000, 1'b1, 1'b0, 3'd4, 16'h8000};
      vecs[5] = '{1'b1, 4'd7, 3'd6, 3'd1, 3'd0, 16'h0000, 1'b1, 1'b0, 3'd5, 16'h7FF9};
      vecs[6] = '{1'b1, 4'd7, 3'd6, 3'd1, 3'd2, 16'h0000, 1'b0, 1'b1, 3'd6, 16'h0000};
      vecs[7] = '{1'b1, 4'd0, 3'd0, 3'd0, 3'd0, 16'hFFFF, 1'b1, 1'b0, 3'd6, 16'h0002};
      vecs[8] = '{1'b0, 4'd0, 3'd0, 3'd0, 3'd0, 16'h0000, 1'b1, 1'b0, 3'd0, 16'hFFFF};
      vecs[9] = '{1'b0, 4'd0, 3'd0, 3'd0, 3'd0, 16'h0000, 1'b0, 1'b0, 3'd0, 16'h0000};

      rst      = 1'b1;
      hold     = 1'b0;
      dbg_addr = '0;
      drive(1'b0, 4'd0, 3'd0, 3'd0, 3'd0, 16'h0000);
      tick();
      tick();
      chk("reset alu_sel", 32'(alu_sel), 32'h1);
      chk("reset wb_valid", 32'(wb_valid), 32'h0);
      rst = 1'b0;
      tick();

      // Reset arriving between issue and write-back discards the instruction.
      drive(1'b1, 4'd0, 3'd1, 3'd0, 3'd0, 16'h0005);
      tick();
      drive(1'b0, 4'd0, 3'd0, 3'd0, 3'd0, 16'h0000);
      chk("li5 alu_a", 32'(alu_a), 32'h5);
      #2 rst = 1'b1;
      #1;
      chk("midrst alu_sel", 32'(alu_sel), 32'h1);
      chk("midrst alu_a", 32'(alu_a), 32'h0);
      tick();
      chk("midrst wb_valid", 32'(wb_valid), 32'h0);
      chk_reg(3'd1, 16'h0000);
      rst = 1'b0;
      tick();
      chk("post-rst wb_valid", 32'(wb_valid), 32'h0);
      chk_reg(3'd1, 16'h0000);
      chk("instr_ready idle", 32'(instr_ready), 32'h1);

      for (int i = 0; i < 10; i++) begin
         drive(vecs[i].v, vecs[i].op, vecs[i].rd, vecs[i].rs1, vecs[i].rs2, vecs[i].imm);
         tick();
         chk($sformatf("v%0d wb_valid", i), 32'(wb_valid), 32'(vecs[i].e_wbv));
         chk($sformatf("v%0d err_div0", i), 32'(err_div0), 32'(vecs[i].e_err));
         if (vecs[i].e_wbv || vecs[i].e_err)
            chk($sformatf("v%0d wb_addr", i), 32'(wb_addr), 32'(vecs[i].e_addr));
         if (vecs[i].e_wbv)
            chk($sformatf("v%0d wb_data", i), 32'(wb_data), 32'(vecs[i].e_data));
      end

      chk_reg(3'd0, 16'h0000);
      chk_reg(3'd1, 16'h0007);
      chk_reg(3'd2, 16'h0003);
      chk_reg(3'd3, 16'h000A);
      chk_reg(3'd4, 16'h8000);
      chk_reg(3'd5, 16'h7FF9);
      chk_reg(3'd6, 16'h0002);
      chk_reg(3'd7, 16'h0000);

      // Hold with SUB r7 = r1 - r2 in EX, and an LI waiting at the input.
      drive(1'b1, 4'd2, 3'd7, 3'd1, 3'd2, 16'h0000);
      tick();
      hold = 1'b1;
      drive(1'b1, 4'd0, 3'd3, 3'd0, 3'd0, 16'h0055);
      #1;
      chk("hold instr_ready", 32'(instr_ready), 32'h0);
      for (int c = 0; c < 3; c++) begin
         tick();
         chk($sformatf("hold%0d wb_valid", c), 32'(wb_valid), 32'h0);
         chk($sformatf("hold%0d alu_a", c), 32'(alu_a), 32'h7);
         chk($sformatf("hold%0d alu_b", c), 32'(alu_b), 32'h3);
         chk($sformatf("hold%0d alu_sel", c), 32'(alu_sel), 32'h2);
      end
      chk_reg(3'd7, 16'h0000);
      hold = 1'b0;
      tick();
      drive(1'b0, 4'd0, 3'd0, 3'd0, 3'd0, 16'h0000);
      chk("release wb_valid", 32'(wb_valid), 32'h1);
      chk("release wb_addr", 32'(wb_addr), 32'h7);
      chk("release wb_data", 32'(wb_data), 32'h4);
      chk("release alu_a", 32'(alu_a), 32'h55);
      tick();
      chk("li after hold wb_valid", 32'(wb_valid), 32'h1);
      chk("li after hold wb_addr", 32'(wb_addr), 32'h3);
      chk("li after hold wb_data", 32'(wb_data), 32'h55);
      tick();
      chk("idle wb_valid", 32'(wb_valid), 32'h0);
      chk_reg(3'd7, 16'h0004);
      chk_reg(3'd3, 16'h0055);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
